mc_control_sequencer: RTL

- Multi-cycle control FSM that sequences the MIPS datapath. Each cycle it drives the select lines of the shared datapath muxes (register-destination 3:1, ALU-B 2:1, write-back 3:1, PC-source 4:1) and the register/memory enables.
- Sits between the instruction register and the datapath, and replaces the single-cycle combinational decoder.
- Stalls FETCH and memory states on a memory ready handshake.

---
 rtl/mc_ctrl_pkg.sv | 67 ++++++
 rtl/mc_alu_decode.sv | 32 +++
 rtl/mc_control_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: FSM states, opcode/funct
// values, ALU operation codes and the datapath mux select values.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_MEM_ADDR = 4'd4,
    ST_MEM_RD   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_WB_MEM   = 4'd7,
    ST_WB_ALU   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JUMP     = 4'd10
  } state_e;

  // Primary opcodes, IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes, IR[5:0]
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_op_e;

  // Register-destination mux
  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  // Write-back mux
  localparam logic [1:0] WBSEL_ALU = 2'b00;
  localparam logic [1:0] WBSEL_MEM = 2'b01;
  localparam logic [1:0] WBSEL_PC4 = 2'b10;

  // PC-source mux
  localparam logic [1:0] PCSRC_PC4  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;
  localparam logic [1:0] PCSRC_RS   = 2'b11;

  function automatic logic is_r_alu(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational ALU operation decode from the current state and the latched instruction
// fields. States that do not use the ALU get ALU_ADD (encoding 000).
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_op_e    alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (state)
      ST_EXEC_R: begin
        case (funct)
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      ST_EXEC_I:   alu_op = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
      ST_MEM_ADDR: alu_op = ALU_ADD;
      // Branches compare by subtracting and letting the datapath report zero.
      ST_BRANCH:   alu_op = ALU_SUB;
      default:     alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_sequencer.sv
// Multi-cycle MIPS control FSM: drives datapath mux selects and register/memory enables
// each cycle, stalling FETCH and memory states on mem_ready.
module mc_control_sequencer
  import mc_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter int         OP_W        = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            ir_write,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic [1:0]      reg_dst_sel,
  output logic            alu_src_b_sel,
  output logic [1:0]      wb_sel,
  output logic [1:0]      pc_src_sel,
  output logic [2:0]      alu_op,
  output logic            retire,
  output logic            illegal,
  output logic [3:0]      state
);

  state_e          cur_state;
  logic [OP_W-1:0] op_q;
  logic [OP_W-1:0] fn_q;
  state_e          dec_target;
  logic            dec_legal;
  alu_op_e         alu_dec;

  // Dispatch uses the live IR fields, which are valid during DECODE.
  always_comb begin
    dec_target = ST_FETCH;
    dec_legal  = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        if (is_r_alu(funct))     dec_target = ST_EXEC_R;
        else if (funct == FN_JR) dec_target = ST_JUMP;
        else                     dec_legal  = 1'b0;
      end
      OP_ADDI, OP_ORI: dec_target = ST_EXEC_I;
      OP_LW, OP_SW:    dec_target = ST_MEM_ADDR;
      OP_BEQ, OP_BNE:  dec_target = ST_BRANCH;
      OP_J, OP_JAL:    dec_target = ST_JUMP;
      default:         dec_legal  = 1'b0;
    endcase
  end

  // NOTE: asynchronous reset sits in the sensitivity list; every register is cleared by it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= state_e'(RESET_STATE);
      op_q      <= '0;
      fn_q      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      case (cur_state)
        ST_FETCH: if (mem_ready) cur_state <= ST_DECODE;
        ST_DECODE: begin
          op_q      <= opcode;
          fn_q      <= funct;
          cur_state <= dec_target;
        end
        ST_EXEC_R, ST_EXEC_I: cur_state <= ST_WB_ALU;
        ST_MEM_ADDR: cur_state <= (op_q == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
        ST_MEM_RD:   if (mem_ready) cur_state <= ST_WB_MEM;
        ST_MEM_WR:   if (mem_ready) cur_state <= ST_FETCH;
        // Single-cycle tail states and undefined encodings all return to FETCH.
        default:     cur_state <= ST_FETCH;
      endcase
    end
  end

  mc_alu_decode u_alu_decode (
    .state  (cur_state),
    .opcode (op_q),
    .funct  (fn_q),
    .alu_op (alu_dec)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_dst_sel   = RDST_RT;
    alu_src_b_sel = 1'b0;
    wb_sel        = WBSEL_ALU;
    pc_src_sel    = PCSRC_PC4;
    alu_op        = ALU_ADD;
    retire        = 1'b0;
    illegal       = 1'b0;
    if (!reset) begin
      alu_op = alu_dec;
      case (cur_state)
        ST_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            pc_src_sel = PCSRC_PC4;
          end
        end
        ST_DECODE: begin
          if (!dec_legal) begin
            illegal = 1'b1;
            retire  = 1'b1;
          end
        end
        ST_EXEC_R:   alu_src_b_sel = 1'b0;
        ST_EXEC_I:   alu_src_b_sel = 1'b1;
        ST_MEM_ADDR: alu_src_b_sel = 1'b1;
        ST_MEM_RD:   mem_read      = 1'b1;
        ST_MEM_WR: begin
          mem_write = 1'b1;
          retire    = mem_ready;
        end
        ST_WB_MEM: begin
          reg_write   = 1'b1;
          wb_sel      = WBSEL_MEM;
          reg_dst_sel = RDST_RT;
          retire      = 1'b1;
        end
        ST_WB_ALU: begin
          reg_write   = 1'b1;
          wb_sel      = WBSEL_ALU;
          reg_dst_sel = (op_q == OP_RTYPE) ? RDST_RD : RDST_RT;
          retire      = 1'b1;
        end
        ST_BRANCH: begin
          alu_src_b_sel = 1'b0;
          pc_src_sel    = PCSRC_BR;
          pc_write      = (op_q == OP_BEQ) ? zero : ~zero;
          retire        = 1'b1;
        end
        ST_JUMP: begin
          pc_write = 1'b1;
          retire   = 1'b1;
          if (op_q == OP_RTYPE) begin
            pc_src_sel = PCSRC_RS;
          end else if (op_q == OP_JAL) begin
            pc_src_sel  = PCSRC_JUMP;
            reg_write   = 1'b1;
            reg_dst_sel = RDST_RA;
            wb_sel      = WBSEL_PC4;
          end else begin
            pc_src_sel = PCSRC_JUMP;
          end
        end
        default: alu_op = ALU_ADD;
      endcase
    end
  end

  assign state = cur_state;

endmodule
